// File: rtl/pr_bus_pkg.sv
// Shared types and device-window constants for the peripheral bus arbiter and bridge.
package pr_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Device windows (inclusive byte ranges), also used by the bridge
    localparam logic [ADDR_W-1:0] TIMER0_BASE = 32'h0000_7f00;
    localparam logic [ADDR_W-1:0] TIMER0_TOP  = 32'h0000_7f0b;
    localparam logic [ADDR_W-1:0] TIMER1_BASE = 32'h0000_7f10;
    localparam logic [ADDR_W-1:0] TIMER1_TOP  = 32'h0000_7f1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One master's request as seen by the arbiter
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } pr_req_t;

endpackage

// File: rtl/pr_addr_decode.sv
// Flags whether a byte address falls inside one of the device windows.
module pr_addr_decode
    import pr_bus_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic              in_window
);

    logic [ADDR_W-1:0] aligned;

    // Word-align the address, then compare against both windows
    always_comb begin
        aligned   = addr & ~ADDR_W'(3);
        in_window = ((aligned >= TIMER0_BASE) && (aligned <= TIMER0_TOP)) ||
                    ((aligned >= TIMER1_BASE) && (aligned <= TIMER1_TOP));
    end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between the CPU (M0) and DMA/debug (M1) ports.
module pr_bus_arbiter
    import pr_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] PrAddr,
    output logic [DATA_W-1:0] PrWD,
    output logic              PrWe,
    input  logic [DATA_W-1:0] PrRD,
    output logic              gnt_id,
    output logic              busy
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              we_q;
    logic              win_q;

    logic              pick;
    pr_req_t           sel_req;
    logic              sel_win;
    logic [DATA_W-1:0] rd_val;

    // Winner selection: a lone requester wins, on contention the one not served last
    always_comb begin
        pick          = m1_req & (~m0_req | ~last);
        sel_req.addr  = pick ? m1_addr  : m0_addr;
        sel_req.wdata = pick ? m1_wdata : m0_wdata;
        sel_req.we    = pick ? m1_we    : m0_we;
        rd_val        = (we_q | ~win_q) ? '0 : PrRD;
    end

    pr_addr_decode u_addr_decode (
        .addr      (sel_req.addr),
        .in_window (sel_win)
    );

    // Arbitration FSM; every bus and master output is registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            we_q     <= 1'b0;
            win_q    <= 1'b0;
            PrAddr   <= '0;
            PrWD     <= '0;
            PrWe     <= 1'b0;
            gnt_id   <= 1'b0;
            busy     <= 1'b0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        we_q   <= sel_req.we;
                        win_q  <= sel_win;
                        PrAddr <= sel_req.addr;
                        PrWD   <= sel_req.wdata;
                        // With no wait cycles the first ACCESS cycle is also the last
                        PrWe   <= (WAIT_CYCLES == 0) & sel_req.we & sel_win;
                        gnt_id <= pick;
                        busy   <= 1'b1;
                        cnt    <= CNT_W'(WAIT_CYCLES);
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - CNT_W'(1);
                        // Raise the strobe going into the final ACCESS cycle
                        PrWe <= (cnt == CNT_W'(1)) & we_q & win_q;
                    end else begin
                        PrWe     <= 1'b0;
                        PrAddr   <= '0;
                        PrWD     <= '0;
                        m0_ack   <= ~gnt_id;
                        m1_ack   <= gnt_id;
                        m0_rdata <= gnt_id ? '0 : rd_val;
                        m1_rdata <= gnt_id ? rd_val : '0;
                        m0_err   <= ~gnt_id & ~win_q;
                        m1_err   <= gnt_id & ~win_q;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    last     <= gnt_id;
                    gnt_id   <= 1'b0;
                    busy     <= 1'b0;
                    m0_ack   <= 1'b0;
                    m0_rdata <= '0;
                    m0_err   <= 1'b0;
                    m1_ack   <= 1'b0;
                    m1_rdata <= '0;
                    m1_err   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter: one instance with no wait cycles, one with three.
module tb_pr_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: WAIT_CYCLES = 0
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] pr_addr, pr_wd, pr_rd;
    logic        pr_we, gnt_id, busy;

    // Instance B: WAIT_CYCLES = 3
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [31:0] b_pr_addr, b_pr_wd;
    logic        b_pr_we, b_gnt_id, b_busy;

    int total = 0;
    int bad   = 0;

    pr_bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .PrAddr(pr_addr), .PrWD(pr_wd), .PrWe(pr_we), .PrRD(pr_rd),
        .gnt_id(gnt_id), .busy(busy)
    );

    pr_bus_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut_w3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_we(b_m0_we),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_we(b_m1_we),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .PrAddr(b_pr_addr), .PrWD(b_pr_wd), .PrWe(b_pr_we), .PrRD(pr_rd),
        .gnt_id(b_gnt_id), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transfer on instance A, entered and left at a negedge in IDLE
    task automatic xact_a(input string name, input bit mst, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit we, input bit win);
        logic [31:0] exp_rd;
        exp_rd = (we || !win) ? 32'h0 : pr_rd;
        if (mst) begin
            m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_we = we;
        end else begin
            m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_we = we;
        end
        @(negedge clk);
        chk({name, "_acc_busy"}, busy, 1);
        chk({name, "_acc_gnt"}, gnt_id, mst);
        chk({name, "_acc_addr"}, pr_addr, addr);
        chk({name, "_acc_wd"}, pr_wd, wdata);
        chk({name, "_acc_we"}, pr_we, we && win);
        chk({name, "_acc_noack"}, m0_ack | m1_ack, 0);
        @(negedge clk);
        chk({name, "_ack_own"}, mst ? m1_ack : m0_ack, 1);
        chk({name, "_ack_other"}, mst ? m0_ack : m1_ack, 0);
        chk({name, "_err"}, mst ? m1_err : m0_err, !win);
        chk({name, "_rdata"}, mst ? m1_rdata : m0_rdata, exp_rd);
        chk({name, "_rdata_other"}, mst ? m0_rdata : m1_rdata, 0);
        chk({name, "_resp_we"}, pr_we, 0);
        chk({name, "_resp_addr"}, pr_addr, 0);
        chk({name, "_resp_wd"}, pr_wd, 0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_ack"}, m0_ack | m1_ack, 0);
    endtask

    // Decode boundary table for M0 reads: address and whether it hits a window
    logic [31:0] dec_addr [8] = '{32'h7f0b, 32'h7f0c, 32'h7f0f, 32'h7f10,
                                  32'h7f1b, 32'h7f1c, 32'h7eff, 32'h1000_7f00};
    bit          dec_win  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset_n  = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
        pr_rd    = 32'h55aa_0011;

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_addr", pr_addr, 0);
        chk("rst_we", pr_we, 0);
        chk("rst_acks", m0_ack | m1_ack, 0);
        chk("rst_b_busy", b_busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Simultaneous requests alternate M0, M1, M0, M1
        for (int r = 0; r < 2; r++) begin
            m0_req = 1; m0_addr = 32'h7f08; m0_we = 0;
            m1_req = 1; m1_addr = 32'h7f18; m1_we = 0;
            @(negedge clk);
            chk("rr_first_gnt", gnt_id, 0);
            chk("rr_first_addr", pr_addr, 32'h7f08);
            @(negedge clk);
            chk("rr_first_ack0", m0_ack, 1);
            chk("rr_first_ack1", m1_ack, 0);
            chk("rr_first_rdata", m0_rdata, 32'h55aa_0011);
            m0_req = 0;
            @(negedge clk);
            chk("rr_gap_busy", busy, 0);
            @(negedge clk);
            chk("rr_second_gnt", gnt_id, 1);
            chk("rr_second_addr", pr_addr, 32'h7f18);
            @(negedge clk);
            chk("rr_second_ack1", m1_ack, 1);
            chk("rr_second_ack0", m0_ack, 0);
            chk("rr_second_rdata", m1_rdata, 32'h55aa_0011);
            m1_req = 0;
            @(negedge clk);
            chk("rr_end_busy", busy, 0);
        end

        xact_a("m0_write", 1'b0, 32'h7f04, 32'h0000_1234, 1'b1, 1'b1);
        pr_rd = 32'h0000_abcd;
        xact_a("m1_read", 1'b1, 32'h7f14, 32'h0, 1'b0, 1'b1);
        xact_a("m0_oow_write", 1'b0, 32'h7f20, 32'h0000_dead, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            xact_a($sformatf("dec%0d", i), 1'b0, dec_addr[i], 32'h0, 1'b0, dec_win[i]);
        xact_a("m1_oow_write", 1'b1, 32'h7f0c, 32'h0000_beef, 1'b1, 1'b0);

        // Three wait cycles: four ACCESS cycles, strobe only in the last
        b_m0_req = 1; b_m0_addr = 32'h7f00; b_m0_wdata = 32'h5a5a; b_m0_we = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("w3_acc%0d_busy", i), b_busy, 1);
            chk($sformatf("w3_acc%0d_addr", i), b_pr_addr, 32'h7f00);
            chk($sformatf("w3_acc%0d_we", i), b_pr_we, (i == 3) ? 1 : 0);
            chk($sformatf("w3_acc%0d_ack", i), b_m0_ack, 0);
        end
        @(negedge clk);
        chk("w3_ack", b_m0_ack, 1);
        chk("w3_err", b_m0_err, 0);
        chk("w3_rdata", b_m0_rdata, 0);
        chk("w3_resp_we", b_pr_we, 0);
        b_m0_req = 0;
        @(negedge clk);
        chk("w3_idle_busy", b_busy, 0);

        // Reset in the middle of ACCESS aborts the transfer
        b_m0_req = 1; b_m0_addr = 32'h7f04; b_m0_wdata = 32'h7777; b_m0_we = 1;
        @(negedge clk);
        chk("abort_pre_busy", b_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", b_busy, 0);
        chk("abort_addr", b_pr_addr, 0);
        chk("abort_wd", b_pr_wd, 0);
        chk("abort_we", b_pr_we, 0);
        chk("abort_ack", b_m0_ack, 0);
        b_m0_req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle%0d", i), {b_busy, b_pr_we, b_m0_ack, b_m1_ack}, 0);
        end

        // Fresh M1 read after reset completes with four ACCESS cycles
        b_m1_req = 1; b_m1_addr = 32'h7f14; b_m1_we = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rearm_acc%0d_gnt", i), {b_busy, b_gnt_id}, 2'b11);
            chk($sformatf("rearm_acc%0d_ack", i), b_m1_ack, 0);
        end
        @(negedge clk);
        chk("rearm_ack", b_m1_ack, 1);
        chk("rearm_err", b_m1_err, 0);
        chk("rearm_rdata", b_m1_rdata, 32'h0000_abcd);
        chk("rearm_m0_ack", b_m0_ack, 0);
        b_m1_req = 0;
        @(negedge clk);
        chk("rearm_idle", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pr_bus_arbiter.md
Name: pr_bus_arbiter

Overview:
- Shares the single peripheral bus in front of the system bridge between two masters: M0 is the CPU data port and M1 is the DMA/debug port.
- Runs round-robin arbitration with a req/ack handshake.
- Latches the winning master's request and drives PrAddr/PrWD/PrWe to the bridge for a parameterised number of wait cycles.
- Registers PrRD and flags accesses outside the device windows as bus errors.

Parameters:
- WAIT_CYCLES, 0, extra ACCESS cycles before the read data is sampled (0..15).
- CNT_W, 4, width of the wait counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- m0_req  in  1  M0 request; held high until m0_ack
- m0_addr  in  32  M0 byte address
- m0_wdata  in  32  M0 write data
- m0_we  in  1  M0 write enable (1 = write, 0 = read)
- m0_ack  out  1  one-cycle completion pulse to M0
- m0_rdata  out  32  M0 read data, valid while m0_ack is high
- m0_err  out  1  M0 address error, valid while m0_ack is high
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata, m1_err: same as M0, for M1
- PrAddr  out  32  address to the bridge
- PrWD  out  32  write data to the bridge
- PrWe  out  1  write strobe to the bridge
- PrRD  in  32  read data from the bridge (combinational)
- gnt_id  out  1  current owner; valid while busy is high
- busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset: clk is the only clock. reset_n is asynchronous, active-low. While reset_n is low:
  - state = IDLE, counter = 0, last = 1 (so M0 wins first).
  - All outputs are 0, including PrAddr/PrWD/PrWe, acks, rdata, err, gnt_id and busy.
  - Reset during ACCESS or RESP aborts the transfer with no ack and no PrWe. The master must re-request after reset.
- IDLE:
  - No request: stay in IDLE; bus outputs held at 0.
  - One request: grant that master.
  - Both requesting: grant the master other than `last`.
  - On grant: latch addr/wdata/we into internal registers, set gnt_id, load counter = WAIT_CYCLES, go to ACCESS.
  - Master inputs are ignored after they are latched.
- ACCESS:
  - PrAddr/PrWD are driven from the latched registers.
  - Counter decrements each cycle while nonzero.
  - On the cycle counter == 0 (the final ACCESS cycle) only:
    - PrWe = latched_we & in_window.
    - Sample PrRD into rdata_reg; rdata_reg = 0 if the access is a write or the address is out of window.
    - err_reg = !in_window.
    - Go to RESP.
  - PrWe is high for exactly one cycle per write transaction.
- Window decode: in_window = word-aligned address ({addr[31:2],2'b00}) in 0x7f00..0x7f0B or 0x7f10..0x7f1B. Out-of-window accesses never assert PrWe.
- RESP:
  - The granted master's ack is high for exactly one cycle, with rdata and err valid; the other master's outputs stay 0.
  - PrAddr/PrWD return to 0.
  - last <= gnt_id; go to IDLE.
- Latency: req seen high at edge k → ACCESS from k+1 → ack during cycle k+2+WAIT_CYCLES.
- Handshake:
  - A master deasserts req, or presents a new request, in the cycle after ack.
  - A req still high in IDLE after ack counts as a new transaction.
  - Round-robin ensures that a waiting master is served next.
- No back-to-back grant without IDLE: a minimum of 1 idle cycle between transactions.
- A request arriving during ACCESS/RESP waits; the master holds req.

Decomposition:
- Shared package pr_bus_pkg holds:
  - State enum {IDLE, ACCESS, RESP}.
  - Window constants TIMER0_BASE=0x7f00, TIMER0_TOP=0x7f0B, TIMER1_BASE=0x7f10, TIMER1_TOP=0x7f1B.
  - These constants are also shared with the bridge.
- One sub-module, pr_addr_decode: combinational, takes a 32-bit address and outputs in_window. The bridge reuses it.

Test Plan:
1. WAIT_CYCLES=0; M0 writes 0x7f04 / 0x00001234 → PrWe=1 with PrAddr=0x7f04 and PrWD=0x1234 for one cycle (k+1); m0_ack at k+2; m0_err=0.
2. Both masters request in the same cycle right after reset → M0 is served first, then M1; both request again → M0 is served, then M1 (strict alternation).
3. M1 reads 0x7f14 with PrRD tied to 0x0000ABCD → m1_rdata=0xABCD and m1_err=0 on m1_ack; PrWe stays 0 throughout.
4. M0 writes 0x7f20 → PrWe never asserts; m0_ack with m0_err=1 and m0_rdata=0.
5. WAIT_CYCLES=3; M0 writes 0x7f00 → ACCESS lasts 4 cycles, PrWe only in the 4th; ack at k+5.
6. reset_n pulled low mid-ACCESS → all outputs are 0 asynchronously; no ack and no PrWe; after release, the block returns to IDLE and a fresh M1 request completes normally.
